// File: rtl/nfu3_pwl_array.sv
// nfu3_pwl_array: LANES-wide piecewise-linear activation with a loadable
// coefficient/breakpoint table. Y = sat(((a*X) >>> FRAC) + b), latency 4, no stall.
module nfu3_pwl_array #(
    parameter int unsigned N     = 16,
    parameter int unsigned LANES = 16,
    parameter int unsigned SEGS  = 16,
    parameter int unsigned FRAC  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_valid,
    input  logic [LANES*N-1:0]      i_X,
    input  logic                    i_load_coef,
    input  logic [$clog2(SEGS)-1:0] i_coef_addr,
    input  logic [2*N-1:0]          i_coef,
    input  logic [N-1:0]            i_bp,
    output logic                    o_valid,
    output logic [LANES*N-1:0]      o_Y,
    output logic                    o_busy,
    output logic                    o_load_err
);

    localparam int unsigned AW = $clog2(SEGS);

    typedef logic signed [N-1:0]   word_t;
    typedef logic signed [2*N-1:0] dword_t;

    localparam word_t AOne = word_t'(1 << FRAC);
    localparam word_t WMax = {1'b0, {(N-1){1'b1}}};
    localparam word_t WMin = {1'b1, {(N-1){1'b0}}};

    // Coefficient table
    word_t a_q  [SEGS];
    word_t a_d  [SEGS];
    word_t b_q  [SEGS];
    word_t b_d  [SEGS];
    word_t bp_q [SEGS];
    word_t bp_d [SEGS];

    // Stage valids and control
    logic v1_q, v1_d, v2_q, v2_d, v3_q, v3_d, v4_q, v4_d;
    logic ov_q, ov_d;
    logic err_q, err_d;
    logic load_ok;

    // Per-lane datapath registers
    word_t  x1_q [LANES];
    word_t  x1_d [LANES];
    word_t  x2_q [LANES];
    word_t  x2_d [LANES];
    word_t  a2_q [LANES];
    word_t  a2_d [LANES];
    word_t  b2_q [LANES];
    word_t  b2_d [LANES];
    dword_t p3_q [LANES];
    dword_t p3_d [LANES];
    word_t  b3_q [LANES];
    word_t  b3_d [LANES];
    word_t  y4_q [LANES];
    word_t  y4_d [LANES];
    word_t  y_q  [LANES];
    word_t  y_d  [LANES];

    logic [AW-1:0] seg [LANES];
    dword_t        sh  [LANES];
    logic [2*N:0]  sum [LANES];

    assign o_valid    = ov_q;
    assign o_busy     = v1_q | v2_q | v3_q;
    assign o_load_err = err_q;

    // Table write: only when nothing upstream of S4 can still read the table
    always_comb begin
        load_ok = i_load_coef && !i_valid && !o_busy;
        err_d   = i_load_coef && !load_ok;
        a_d     = a_q;
        b_d     = b_q;
        bp_d    = bp_q;
        if (load_ok) begin
            a_d[i_coef_addr]  = word_t'(i_coef[2*N-1:N]);
            b_d[i_coef_addr]  = word_t'(i_coef[N-1:0]);
            bp_d[i_coef_addr] = word_t'(i_bp);
        end
    end

    // Valid pipeline
    always_comb begin
        v1_d = i_valid;
        v2_d = v1_q;
        v3_d = v2_q;
        v4_d = v3_q;
        ov_d = v4_q;
    end

    // Per-lane datapath: S1 capture, S2 segment lookup, S3 multiply, S4 shift/add/sat
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            x1_d[l] = word_t'(i_X[l*N +: N]);

            // bp[0] is never compared; seg is the count of breakpoints at or below X
            seg[l] = '0;
            for (int k = 1; k < SEGS; k++) begin
                if (x1_q[l] >= bp_q[k]) begin
                    seg[l] = seg[l] + AW'(1);
                end
            end
            x2_d[l] = x1_q[l];
            a2_d[l] = a_q[seg[l]];
            b2_d[l] = b_q[seg[l]];

            p3_d[l] = dword_t'(a2_q[l]) * dword_t'(x2_q[l]);
            b3_d[l] = b2_q[l];

            sh[l]  = p3_q[l] >>> FRAC;
            sum[l] = {sh[l][2*N-1], sh[l]} + {{(N+1){b3_q[l][N-1]}}, b3_q[l]};
            // In range iff the bits above the result sign all match it
            if ((&sum[l][2*N:N-1]) || !(|sum[l][2*N:N-1])) begin
                y4_d[l] = word_t'(sum[l][N-1:0]);
            end else if (sum[l][2*N]) begin
                y4_d[l] = WMin;
            end else begin
                y4_d[l] = WMax;
            end

            y_d[l] = v4_q ? y4_q[l] : y_q[l];
        end
    end

    // Output packing
    always_comb begin
        o_Y = '0;
        for (int l = 0; l < LANES; l++) begin
            o_Y[l*N +: N] = y_q[l];
        end
    end

    // State registers with synchronous reset to the identity table
    always_ff @(posedge clk) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            v3_q  <= 1'b0;
            v4_q  <= 1'b0;
            ov_q  <= 1'b0;
            err_q <= 1'b0;
            for (int s = 0; s < SEGS; s++) begin
                a_q[s]  <= AOne;
                b_q[s]  <= '0;
                bp_q[s] <= WMax;
            end
            for (int l = 0; l < LANES; l++) begin
                x1_q[l] <= '0;
                x2_q[l] <= '0;
                a2_q[l] <= '0;
                b2_q[l] <= '0;
                p3_q[l] <= '0;
                b3_q[l] <= '0;
                y4_q[l] <= '0;
                y_q[l]  <= '0;
            end
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            v3_q  <= v3_d;
            v4_q  <= v4_d;
            ov_q  <= ov_d;
            err_q <= err_d;
            a_q   <= a_d;
            b_q   <= b_d;
            bp_q  <= bp_d;
            x1_q  <= x1_d;
            x2_q  <= x2_d;
            a2_q  <= a2_d;
            b2_q  <= b2_d;
            p3_q  <= p3_d;
            b3_q  <= b3_d;
            y4_q  <= y4_d;
            y_q   <= y_d;
        end
    end

endmodule

// File: tb/tb_nfu3_pwl_array.sv
// Directed bench for nfu3_pwl_array with N=16, FRAC=8, LANES=4, SEGS=4.
module tb_nfu3_pwl_array;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_valid;
    logic [63:0] i_X;
    logic        i_load_coef;
    logic [1:0]  i_coef_addr;
    logic [31:0] i_coef;
    logic [15:0] i_bp;
    logic        o_valid;
    logic [63:0] o_Y;
    logic        o_busy;
    logic        o_load_err;

    int tests = 0;
    int fails = 0;

    // Reference table
    logic signed [15:0] ma  [4];
    logic signed [15:0] mb  [4];
    logic signed [15:0] mbp [4];

    logic [63:0] hv [3];
    logic [63:0] sv [20];
    logic [63:0] se [20];

    nfu3_pwl_array #(
        .N     (16),
        .LANES (4),
        .SEGS  (4),
        .FRAC  (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .i_valid     (i_valid),
        .i_X         (i_X),
        .i_load_coef (i_load_coef),
        .i_coef_addr (i_coef_addr),
        .i_coef      (i_coef),
        .i_bp        (i_bp),
        .o_valid     (o_valid),
        .o_Y         (o_Y),
        .o_busy      (o_busy),
        .o_load_err  (o_load_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_identity();
        for (int s = 0; s < 4; s++) begin
            ma[s]  = 16'sh0100;
            mb[s]  = 16'sh0000;
            mbp[s] = 16'sh7FFF;
        end
    endtask

    function automatic logic [15:0] ref_lane(input logic signed [15:0] x);
        int     sg;
        longint p;
        longint s;
        sg = 0;
        for (int k = 1; k < 4; k++) if (x >= mbp[k]) sg++;
        p = longint'(ma[sg]) * longint'(x);
        s = (p >>> 8) + longint'(mb[sg]);
        if (s > 32767) s = 32767;
        if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    function automatic logic [63:0] ref_vec(input logic [63:0] x);
        logic [63:0] r;
        for (int l = 0; l < 4; l++) r[l*16 +: 16] = ref_lane(x[l*16 +: 16]);
        return r;
    endfunction

    // One isolated vector: exact latency 4, single-cycle valid, held output
    task automatic run_vec(input string tag, input logic [63:0] x, input logic [63:0] exp);
        i_X     = x;
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            tick();
            check_eq({tag, "_early"}, {63'd0, o_valid}, 64'd0);
        end
        tick();
        check_eq({tag, "_valid"}, {63'd0, o_valid}, 64'd1);
        check_eq({tag, "_y"}, o_Y, exp);
        tick();
        check_eq({tag, "_once"}, {63'd0, o_valid}, 64'd0);
        check_eq({tag, "_hold"}, o_Y, exp);
    endtask

    task automatic load(input logic [1:0] addr, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] bp, input bit expect_ok);
        i_load_coef = 1'b1;
        i_coef_addr = addr;
        i_coef      = {a, b};
        i_bp        = bp;
        tick();
        i_load_coef = 1'b0;
        check_eq("load_err", {63'd0, o_load_err}, {63'd0, !expect_ok});
        if (expect_ok) begin
            ma[addr]  = a;
            mb[addr]  = b;
            mbp[addr] = bp;
        end
    endtask

    initial begin
        reset       = 1'b1;
        i_valid     = 1'b0;
        i_X         = '0;
        i_load_coef = 1'b0;
        i_coef_addr = '0;
        i_coef      = '0;
        i_bp        = '0;
        model_identity();

        // 1. Identity after reset
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_valid", {63'd0, o_valid}, 64'd0);
        check_eq("rst_y", o_Y, 64'd0);
        check_eq("rst_busy", {63'd0, o_busy}, 64'd0);
        check_eq("rst_err", {63'd0, o_load_err}, 64'd0);
        run_vec("ident", 64'h8000_7FFF_FF00_0123, 64'h8000_7FFF_FF00_0123);

        // 2. ReLU
        load(2'd0, 16'h0000, 16'h0000, 16'h8000, 1'b1);
        for (int s = 1; s < 4; s++) load(2'(s), 16'h0100, 16'h0000, 16'h0000, 1'b1);
        run_vec("relu", 64'h7FFF_0000_0007_FFFB, 64'h7FFF_0000_0007_0000);

        // 3. Scale, offset, saturation, floor
        for (int s = 0; s < 4; s++) load(2'(s), 16'h0200, 16'h0010, 16'h0000, 1'b1);
        run_vec("scale", 64'hA000_C000_4000_0100, 64'h8000_8010_7FFF_0210);
        for (int s = 0; s < 4; s++) load(2'(s), 16'h0080, 16'h0000, 16'h0000, 1'b1);
        run_vec("floor", 64'h0100_FFFF_0003_FFFD, 64'h0080_FFFF_0001_FFFE);

        // 4. Load hazard: loads in cycles 1 (with valid) and 3 (busy) are rejected
        hv[0] = 64'h00C8_0005_FF9C_FFFD;
        hv[1] = 64'h8000_0100_FFFF_7FFF;
        hv[2] = 64'hFF00_0002_C000_0001;
        for (int c = 0; c < 9; c++) begin
            i_valid     = (c < 3);
            i_X         = (c < 3) ? hv[c] : 64'd0;
            i_load_coef = (c == 1 || c == 3);
            i_coef_addr = 2'd0;
            i_coef      = 32'h7000_1234;
            i_bp        = 16'h8000;
            tick();
            check_eq("hz_err", {63'd0, o_load_err}, {63'd0, (c == 1 || c == 3)});
            check_eq("hz_busy", {63'd0, o_busy}, {63'd0, (c <= 4)});
            check_eq("hz_valid", {63'd0, o_valid}, {63'd0, (c >= 4 && c <= 6)});
            if (c >= 4 && c <= 6) check_eq("hz_y", o_Y, ref_vec(hv[c-4]));
        end
        i_valid     = 1'b0;
        i_load_coef = 1'b0;
        load(2'd0, 16'h0300, 16'h0005, 16'h8000, 1'b1);
        run_vec("hz_new", 64'h0000_FF00_0001_FFFE, 64'h0000_FD05_0000_FFFF);

        // 5. Streaming 20 back-to-back vectors
        for (int c = 0; c < 20; c++) begin
            sv[c] = {$urandom, $urandom};
            se[c] = ref_vec(sv[c]);
        end
        for (int c = 0; c < 24; c++) begin
            i_valid = (c < 20);
            i_X     = (c < 20) ? sv[c] : 64'd0;
            tick();
            check_eq("st_valid", {63'd0, o_valid}, {63'd0, (c >= 4)});
            if (c >= 4) check_eq("st_y", o_Y, se[c-4]);
        end
        i_valid = 1'b0;
        tick();
        check_eq("st_end", {63'd0, o_valid}, 64'd0);

        // 6. Reset with v1..v3 set
        for (int c = 0; c < 3; c++) begin
            i_valid = 1'b1;
            i_X     = hv[c];
            tick();
        end
        i_valid = 1'b0;
        check_eq("mr_busy_pre", {63'd0, o_busy}, 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        model_identity();
        check_eq("mr_valid", {63'd0, o_valid}, 64'd0);
        check_eq("mr_busy", {63'd0, o_busy}, 64'd0);
        check_eq("mr_y", o_Y, 64'd0);
        for (int c = 0; c < 5; c++) begin
            tick();
            check_eq("mr_stale", {63'd0, o_valid}, 64'd0);
        end
        run_vec("mr_ident", 64'hC000_8000_1234_FFFB, 64'hC000_8000_1234_FFFB);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
